spi_sclk_gen: RTL and testbench



---
 rtl/spi_sclk_gen_if.sv | 60 ++++++
 rtl/spi_sclk_gen.sv | 188 ++++++++++++++++++
 tb/tb_spi_sclk_gen.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_sclk_gen_if.sv
// rtl/spi_sclk_gen_if.sv - request/strobe bundle between SPI sequencer and SCLK generator
//
// Signals:
//   start         request pulse (requester -> generator)
//   div           half-period minus one (requester -> generator)
//   cpol          SCLK idle level, only when SPI_CPOL_EN is defined
//   clk_div       divided serial clock (generator -> shift stage)
//   leading_edge  first-toggle strobe of each SCLK period
//   trailing_edge second-toggle strobe of each SCLK period
//   valid_latch   byte-complete strobe
//   cs_n          active-low chip select
//   busy          transfer in progress
//   done          one-cycle completion pulse
// Optional feature macro: SPI_CPOL_EN
interface spi_sclk_gen_if #(
    parameter int DIV_W = 8
);
    logic             start;
    logic [DIV_W-1:0] div;
`ifdef SPI_CPOL_EN
    logic             cpol;
`endif
    logic             clk_div;
    logic             leading_edge;
    logic             trailing_edge;
    logic             valid_latch;
    logic             cs_n;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output div,
`ifdef SPI_CPOL_EN
        output cpol,
`endif
        input  clk_div,
        input  leading_edge,
        input  trailing_edge,
        input  valid_latch,
        input  cs_n,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  div,
`ifdef SPI_CPOL_EN
        input  cpol,
`endif
        output clk_div,
        output leading_edge,
        output trailing_edge,
        output valid_latch,
        output cs_n,
        output busy,
        output done
    );
endinterface

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - SPI serial clock, edge strobe and chip-select sequencer
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   spi_sclk_gen_if.slave: start/div(/cpol) in; clk_div, leading_edge,
//         trailing_edge, valid_latch, cs_n, busy, done out (all registered)
// Parameters:
//   DIV_W      width of the divider value
//   DATA_BITS  SCLK periods per transfer (1..255)
// Optional feature macro: SPI_CPOL_EN (adds cpol, latched idle level)
module spi_sclk_gen #(
    parameter int DIV_W     = 8,
    parameter int DATA_BITS = 8
) (
    input  logic          clk,
    input  logic          rst,
    spi_sclk_gen_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD
    } state_t;

    localparam logic [7:0] LAST_EDGE = 8'(DATA_BITS);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [7:0]       edge_q, edge_d;
    logic             clk_div_q, clk_div_d;
    logic             le_q, le_d;
    logic             te_q, te_d;
    logic             vl_q, vl_d;
    logic             cs_n_q, cs_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             idle_lvl;
    logic             start_lvl;
    logic             tc;

`ifdef SPI_CPOL_EN
    logic             cpol_q, cpol_d;
    assign idle_lvl  = cpol_q;
    assign start_lvl = bus.cpol;
`else
    assign idle_lvl  = 1'b0;
    assign start_lvl = 1'b0;
`endif

    // Terminal count of the current half period.
    assign tc = (cnt_q == div_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            cnt_q     <= '0;
            edge_q    <= '0;
            clk_div_q <= 1'b0;
            le_q      <= 1'b0;
            te_q      <= 1'b0;
            vl_q      <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SPI_CPOL_EN
            cpol_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            clk_div_q <= clk_div_d;
            le_q      <= le_d;
            te_q      <= te_d;
            vl_q      <= vl_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SPI_CPOL_EN
            cpol_q    <= cpol_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        edge_d    = edge_q;
        clk_div_d = clk_div_q;
        le_d      = 1'b0;
        te_d      = 1'b0;
        vl_d      = 1'b0;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef SPI_CPOL_EN
        cpol_d    = cpol_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                cs_n_d    = 1'b1;
                busy_d    = 1'b0;
                clk_div_d = idle_lvl;
                // done_q marks the cycle IDLE was re-entered; a start seen
                // there is dropped so back-to-back transfers get one idle cycle.
                if (bus.start && !done_q) begin
                    state_d   = S_SETUP;
                    div_d     = bus.div;
                    cnt_d     = '0;
                    edge_d    = '0;
                    clk_div_d = start_lvl;
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
`ifdef SPI_CPOL_EN
                    cpol_d    = bus.cpol;
`endif
                end
            end

            S_SETUP: begin
                // End of setup coincides with the first (leading) toggle.
                if (tc) begin
                    cnt_d     = '0;
                    clk_div_d = ~clk_div_q;
                    le_d      = 1'b1;
                    state_d   = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_SHIFT: begin
                if (tc) begin
                    cnt_d     = '0;
                    clk_div_d = ~clk_div_q;
                    // Toggling away from the idle level is a leading edge.
                    if (clk_div_q == idle_lvl) begin
                        le_d = 1'b1;
                    end else begin
                        te_d   = 1'b1;
                        edge_d = edge_q + 8'd1;
                        if (edge_q + 8'd1 == LAST_EDGE) begin
                            state_d = S_HOLD;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_HOLD: begin
                if (tc) begin
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                    cs_n_d    = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    vl_d      = 1'b1;
                    clk_div_d = idle_lvl;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.clk_div       = clk_div_q;
    assign bus.leading_edge  = le_q;
    assign bus.trailing_edge = te_q;
    assign bus.valid_latch   = vl_q;
    assign bus.cs_n          = cs_n_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb/tb_spi_sclk_gen.sv - scoreboard testbench for spi_sclk_gen
module tb_spi_sclk_gen;

    localparam int DIV_W = 8;
    localparam int NB    = 8;

    localparam int K_CSF  = 0;
    localparam int K_LEAD = 1;
    localparam int K_TRL  = 2;
    localparam int K_DONE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    spi_sclk_gen_if #(.DIV_W(DIV_W)) bus ();

    spi_sclk_gen #(.DIV_W(DIV_W), .DATA_BITS(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected-event queue: written by stimulus (wr_ptr), read by monitor (rd_ptr).
    int   exp_cyc  [0:511];
    int   exp_kind [0:511];
    int   wr_ptr = 0;
    int   rd_ptr = 0;

    logic idle_exp = 1'b0;

    // Check requests from the stimulus side, executed by the monitor.
    int    chk_id = 0;
    int    chk_seen = 0;
    string chk_name;
    int    chk_act;
    int    chk_exp;

    int checks   = 0;
    int failures = 0;

    logic prev_clk = 1'b0;
    logic prev_cs  = 1'b1;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        int kind;
        logic ev;
        if (chk_id != chk_seen) begin
            chk_seen = chk_id;
            checks++;
            if (chk_act != chk_exp) begin
                failures++;
                $display("FAIL %s: got %0d expected %0d", chk_name, chk_act, chk_exp);
            end
        end
        if (rst) begin
            checks++;
            if ({bus.clk_div, bus.cs_n, bus.busy, bus.done, bus.leading_edge,
                 bus.trailing_edge, bus.valid_latch} != 7'b0100000) begin
                failures++;
                $display("FAIL reset_values at cycle %0d: got %b expected 0100000", cyc,
                         {bus.clk_div, bus.cs_n, bus.busy, bus.done, bus.leading_edge,
                          bus.trailing_edge, bus.valid_latch});
            end
        end else begin
            ev = 1'b1;
            kind = K_CSF;
            if (!bus.cs_n && prev_cs)   kind = K_CSF;
            else if (bus.leading_edge)  kind = K_LEAD;
            else if (bus.trailing_edge) kind = K_TRL;
            else if (bus.done || bus.valid_latch) kind = K_DONE;
            else ev = 1'b0;

            if (ev) begin
                checks++;
                if (rd_ptr == wr_ptr) begin
                    failures++;
                    $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
                end else begin
                    if (exp_cyc[rd_ptr] != cyc || exp_kind[rd_ptr] != kind) begin
                        failures++;
                        $display("FAIL event_order: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                                 kind, cyc, exp_kind[rd_ptr], exp_cyc[rd_ptr]);
                    end
                    rd_ptr++;
                end
                checks++;
                case (kind)
                    K_CSF: if (!(bus.busy && bus.clk_div == idle_exp)) begin
                        failures++;
                        $display("FAIL cs_fall_state: got busy=%b clk_div=%b expected busy=1 clk_div=%b",
                                 bus.busy, bus.clk_div, idle_exp);
                    end
                    K_LEAD: if (bus.clk_div != ~idle_exp || bus.trailing_edge) begin
                        failures++;
                        $display("FAIL lead_level: got clk_div=%b te=%b expected clk_div=%b te=0",
                                 bus.clk_div, bus.trailing_edge, ~idle_exp);
                    end
                    K_TRL: if (bus.clk_div != idle_exp) begin
                        failures++;
                        $display("FAIL trail_level: got clk_div=%b expected %b", bus.clk_div, idle_exp);
                    end
                    default: if (!(bus.done && bus.valid_latch && bus.cs_n && !bus.busy
                                   && bus.clk_div == idle_exp)) begin
                        failures++;
                        $display("FAIL done_state: got done=%b vl=%b cs_n=%b busy=%b clk_div=%b expected 1 1 1 0 %b",
                                 bus.done, bus.valid_latch, bus.cs_n, bus.busy, bus.clk_div, idle_exp);
                    end
                endcase
            end else if (bus.clk_div != prev_clk) begin
                checks++;
                failures++;
                $display("FAIL stray_toggle: got clk_div change at cycle %0d, expected no change", cyc);
            end
        end
        prev_clk = bus.clk_div;
        prev_cs  = bus.cs_n;
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input int c, input int k);
        exp_cyc[wr_ptr]  = c;
        exp_kind[wr_ptr] = k;
        wr_ptr++;
    endtask

    // Expected events of a transfer whose start is sampled in cycle t.
    task automatic push_xfer(input int t, input int h, input int limit);
        if (t + 1 < limit) push(t + 1, K_CSF);
        for (int k = 1; k <= 2 * NB; k++)
            if (t + 1 + k * h < limit) push(t + 1 + k * h, (k % 2 == 1) ? K_LEAD : K_TRL);
        if (t + 1 + (2 * NB + 1) * h < limit) push(t + 1 + (2 * NB + 1) * h, K_DONE);
    endtask

    task automatic go_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic post_check(input string name, input int act, input int expv);
        chk_name = name;
        chk_act  = act;
        chk_exp  = expv;
        chk_id++;
        @(negedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (rd_ptr != wr_ptr && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        post_check(name, wr_ptr - rd_ptr, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_xfer(input int d, input int h, input string name);
        int t;
        t = cyc + 1;
        go_to(t);
        bus.div   = DIV_W'(d);
        bus.start = 1'b1;
        push_xfer(t, h, 32'h7fff_ffff);
        go_to(t + 1);
        bus.start = 1'b0;
        drain(name, 40 * h + 20);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t;
        bus.start = 1'b0;
        bus.div   = '0;
`ifdef SPI_CPOL_EN
        bus.cpol  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // div=1: H=2, done at +35
        run_xfer(1, 2, "xfer_div1");
        // div=0: H=1, done at +18
        run_xfer(0, 1, "xfer_div0");

        // start pulse and div change mid-transfer are ignored
        t = cyc + 1;
        go_to(t);
        bus.div = 8'd1;
        bus.start = 1'b1;
        push_xfer(t, 2, 32'h7fff_ffff);
        go_to(t + 1);
        bus.start = 1'b0;
        go_to(t + 10);
        bus.start = 1'b1;
        go_to(t + 11);
        bus.start = 1'b0;
        go_to(t + 12);
        bus.div = 8'd5;
        drain("xfer_ignore_mid", 80);
        run_xfer(5, 6, "xfer_div5");

        // reset at cycle 12 of a transfer
        t = cyc + 1;
        go_to(t);
        bus.div = 8'd1;
        bus.start = 1'b1;
        push_xfer(t, 2, t + 12);
        go_to(t + 1);
        bus.start = 1'b0;
        go_to(t + 12);
        rst = 1'b1;
        go_to(t + 14);
        rst = 1'b0;
        go_to(t + 45);
        post_check("reset_abort_queue", wr_ptr - rd_ptr, 0);
        run_xfer(2, 3, "xfer_after_reset");

        // back-to-back with start held high
        t = cyc + 1;
        go_to(t);
        bus.div = 8'd0;
        bus.start = 1'b1;
        push_xfer(t, 1, 32'h7fff_ffff);
        push_xfer(t + 19, 1, 32'h7fff_ffff);
        go_to(t + 20);
        bus.start = 1'b0;
        drain("back_to_back", 60);

`ifdef SPI_CPOL_EN
        bus.cpol = 1'b1;
        idle_exp = 1'b1;
        run_xfer(1, 2, "cpol1_xfer");
        bus.cpol = 1'b0;
        idle_exp = 1'b0;
        run_xfer(1, 2, "cpol0_xfer");
`endif

        post_check("final_queue", wr_ptr - rd_ptr, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
